// File: rtl/stage_if_fq_pkg.sv
// Purpose: shared constants for the instruction-fetch stage with fetch queue.
// Latency: n/a (constants only).
// Backpressure: n/a.
package stage_if_fq_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 32;
    localparam int unsigned WORD_WIDTH_DEF = 32;
    localparam int unsigned FQ_DEPTH_DEF   = 4;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;

    // ADDI x0,x0,0 -- shown on out_inst whenever the queue head is not valid
    localparam logic [31:0] NOP_INST       = 32'h0000_0013;

endpackage

// File: rtl/stage_if_fq_fetch_fifo.sv
// Purpose: synchronous FIFO holding fetched {pc, inst[, misalign]} entries.
// Latency: push visible at the head the cycle after the write.
// Backpressure: caller guarantees no push when full unless popping the same cycle.
//
// Ports: clk/rst (sync, active-high), flush (wins over push/pop),
//        push/push_dat, pop/pop_dat (head, combinational), count/full/empty.
module stage_if_fq_fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // one extra pointer bit separates full from empty
    logic [AW:0]      wr_q, rd_q;
    logic             do_push, do_pop;

    assign count   = wr_q - rd_q;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (wr_q == rd_q);
    assign pop_dat = mem_q[rd_q[AW-1:0]];

    // full+pop+push is legal: head is read out while its slot is rewritten at the edge
    assign do_push = push && (!full || pop) && !flush && !rst;
    assign do_pop  = pop && !empty && !flush && !rst;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/stage_if_fq.sv
// Purpose: instruction fetch stage; issues imem reads and queues {pc, inst} for ID.
// Latency: request accepted in cycle N -> entry valid to ID in cycle N+2; 1 entry/cycle sustained.
// Backpressure: out_ready low holds the head; requests stop once queued + in-flight reaches FQ_DEPTH.
//
// Ports: clk/rst (sync, active-high); redirect_en/redirect_tgt (flush + new pc);
//        imem_req/imem_addr/imem_gnt request side, imem_rvalid/imem_rdata response side;
//        out_valid/out_ready/out_inst/out_pc (+ out_misalign) towards ID.
// Option: define IF_MISALIGN_CHK_EN to trap misaligned redirect targets (adds out_misalign);
//         otherwise misaligned targets are aligned down and fetch continues.
module stage_if_fq
    import stage_if_fq_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH         = ADDR_WIDTH_DEF,
    parameter int unsigned WORD_WIDTH         = WORD_WIDTH_DEF,
    parameter int unsigned FQ_DEPTH           = FQ_DEPTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_PC_DEF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_en,
    input  logic [ADDR_WIDTH-1:0] redirect_tgt,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [WORD_WIDTH-1:0] imem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_inst,
`ifdef IF_MISALIGN_CHK_EN
    output logic                  out_misalign,
`endif
    output logic [ADDR_WIDTH-1:0] out_pc
);

    localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;
`ifdef IF_MISALIGN_CHK_EN
    localparam int unsigned EW = ADDR_WIDTH + WORD_WIDTH + 1;
`else
    localparam int unsigned EW = ADDR_WIDTH + WORD_WIDTH;
`endif

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] tag_q, tag_d;
    logic                  inflight_q, inflight_d;
    logic                  halt;
    logic                  accept, pop, push, rd_ok;
    logic [EW-1:0]         push_dat, head_dat;
    logic [CW-1:0]         fq_count;
    logic                  fq_full, fq_empty;
    logic [CW:0]           occ;

    assign out_valid = !fq_empty && !rst;
    assign pop       = out_valid && out_ready;

    // credit: entries that will be held after this cycle's pop plus the read still returning
    assign occ       = {1'b0, fq_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    assign imem_req  = !rst && !redirect_en && !halt && (occ < (CW+1)'(FQ_DEPTH));
    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_gnt;

    // inflight_q is cleared by redirect/reset, so the matching rvalid is squashed
    assign rd_ok     = imem_rvalid && inflight_q && !redirect_en && !rst;

`ifdef IF_MISALIGN_CHK_EN
    logic halt_q, halt_d, mis_pend_q, mis_pend_d, tgt_mis;

    assign tgt_mis  = (redirect_tgt[1:0] != 2'b00);
    assign halt     = halt_q;
    // while halted pc_q still holds the misaligned target, which becomes the trap entry pc
    assign push     = rd_ok || (mis_pend_q && !redirect_en && !rst);
    assign push_dat = mis_pend_q ? {pc_q, WORD_WIDTH'(NOP_INST), 1'b1}
                                 : {tag_q, imem_rdata, 1'b0};
    assign out_misalign = out_valid && head_dat[0];
`else
    assign halt     = 1'b0;
    assign push     = rd_ok;
    assign push_dat = {tag_q, imem_rdata};
`endif

    always_comb begin
        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = accept;
`ifdef IF_MISALIGN_CHK_EN
        halt_d     = halt_q;
        mis_pend_d = 1'b0;
`endif
        if (redirect_en) begin
`ifdef IF_MISALIGN_CHK_EN
            pc_d       = redirect_tgt;
            halt_d     = tgt_mis;
            mis_pend_d = tgt_mis;
`else
            pc_d       = redirect_tgt & ~ADDR_WIDTH'(3);
`endif
        end else if (accept) begin
            pc_d  = pc_q + ADDR_WIDTH'(4);
            tag_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
`ifdef IF_MISALIGN_CHK_EN
            halt_q     <= 1'b0;
            mis_pend_q <= 1'b0;
`endif
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
`ifdef IF_MISALIGN_CHK_EN
            halt_q     <= halt_d;
            mis_pend_q <= mis_pend_d;
`endif
        end
    end

    stage_if_fq_fetch_fifo #(
        .DEPTH (FQ_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_en),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (head_dat),
        .count    (fq_count),
        .full     (fq_full),
        .empty    (fq_empty)
    );

    assign out_pc   = out_valid ? head_dat[EW-1 -: ADDR_WIDTH] : '0;
    assign out_inst = out_valid ? head_dat[EW-ADDR_WIDTH-1 -: WORD_WIDTH]
                                : WORD_WIDTH'(NOP_INST);

    // the credit check makes a push into a full queue without a pop impossible
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (push && !redirect_en) |-> (!fq_full || pop));

endmodule
